// File: rtl/instr_encoder_loader_if.sv
// Bundle-in / imem-out bus of the instruction encoder-loader.
// master = harness side (offers bundles, acks writes); slave = loader.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [4:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;
  logic [4:0]        aluop;
  logic [16:0]       imm;
  logic [26:0]       target;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              mem_ready;

  modport master (
    output in_valid, in_type, opcode, rd, rs, rt, shamt, aluop, imm, target, mem_ready,
    input  in_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_type, opcode, rd, rs, rt, shamt, aluop, imm, target, mem_ready,
    output in_ready, imem_wren, imem_addr, imem_data
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs instruction field bundles into 32-bit R/I/JI/JII words, buffers them
// in a 4-entry FIFO and writes them to consecutive imem addresses from a base.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                finish_i,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]     count_o,
  output logic                overflow_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                in_ready_q, in_ready_d;
  logic                wren_q, wren_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [WORD_W-1:0]   word_c;
  logic                push_c;
  logic                pop_c;

  // Field packing; fields not used by the selected format are dropped.
  always_comb begin
    word_c = '0;
    unique case (bus.in_type)
      2'd0:    word_c = {bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.aluop, 2'b00};
      2'd1:    word_c = {bus.opcode, bus.rd, bus.rs, bus.imm};
      2'd2:    word_c = {bus.opcode, bus.target};
      default: word_c = {bus.opcode, bus.rd, 22'b0};
    endcase
  end

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = wren_q & bus.mem_ready;

  // Next state, FIFO bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    wr_addr_d  = wr_addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          wr_addr_d  = base_addr_i;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_RUN:   if (finish_i) state_d = S_DRAIN;
      S_DRAIN: if (fcnt_q == '0 && !pop_c) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (push_c) begin
      mem_d[wr_ptr_q] = word_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      count_d   = count_q + (ADDR_W + 1)'(1);
      if (&wr_addr_q) overflow_d = 1'b1;
    end
    fcnt_d = fcnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    in_ready_d = (state_d == S_RUN) && (fcnt_d != CNT_W'(DEPTH));
    wren_d     = busy_d && (fcnt_d != '0);
    data_d     = mem_d[rd_ptr_d];
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      wr_addr_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      in_ready_q <= in_ready_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.imem_wren = wren_q;
  assign bus.imem_addr = wr_addr_q;
  assign bus.imem_data = data_q;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a
// transaction-level model (queue of pending words, phase, address counter).
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              finish_i;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              done_o;
  logic              busy_o;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .finish_i   (finish_i),
    .bus        (bus),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 loading, 2 draining, 3 done pulse.
  int                phase;
  logic [31:0]       mq[$];
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W:0]   m_count;
  logic              m_ovf;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  bit                last_hs;
  bit                last_wr;
  int                done_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [1:0] t, input logic [4:0] op,
      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] sh, input logic [4:0] al, input logic [16:0] imm,
      input logic [26:0] tg);
    logic [31:0] w;
    w = 32'(op) << 27;
    case (t)
      2'd0: w = w | (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12) | (32'(sh) << 7) | (32'(al) << 2);
      2'd1: w = w | (32'(rd) << 22) | (32'(rs) << 17) | 32'(imm);
      2'd2: w = w | 32'(tg);
      default: w = w | (32'(rd) << 22);
    endcase
    return w;
  endfunction

  task automatic model_reset();
    phase   = 0;
    mq.delete();
    m_addr  = '0;
    m_count = '0;
    m_ovf   = 1'b0;
  endtask

  // Check all outputs against the model for the current cycle, then advance one clock.
  task automatic step();
    bit e_busy, e_rdy, e_wren;
    int sz;
    sz     = mq.size();
    e_busy = (phase == 1) || (phase == 2);
    e_rdy  = (phase == 1) && (sz < 4);
    e_wren = e_busy && (sz > 0);
    chk("busy", 64'(busy_o), 64'(e_busy));
    chk("in_ready", 64'(bus.in_ready), 64'(e_rdy));
    chk("wren", 64'(bus.imem_wren), 64'(e_wren));
    chk("done", 64'(done_o), 64'(phase == 3));
    chk("count", 64'(count_o), 64'(m_count));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    if (e_wren) begin
      chk("addr", 64'(bus.imem_addr), 64'(m_addr));
      chk("data", 64'(bus.imem_data), 64'(mq[0]));
    end
    if (done_o) done_seen++;
    last_wr = e_wren && bus.mem_ready;
    last_hs = e_rdy && bus.in_valid;
    if (last_wr) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_data);
      void'(mq.pop_front());
      if (m_addr == {ADDR_W{1'b1}}) m_ovf = 1'b1;
      m_addr  = m_addr + 1'b1;
      m_count = m_count + 1'b1;
    end
    if (last_hs)
      mq.push_back(encode(bus.in_type, bus.opcode, bus.rd, bus.rs, bus.rt,
                          bus.shamt, bus.aluop, bus.imm, bus.target));
    case (phase)
      0: if (start_i) begin
           phase   = 1;
           m_addr  = base_addr_i;
           m_count = '0;
           m_ovf   = 1'b0;
         end
      1: if (finish_i) phase = 2;
      2: if (sz == 0 && !last_wr) phase = 3;
      default: phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_fields();
    bus.in_type = 2'($urandom);
    bus.opcode  = 5'($urandom);
    bus.rd      = 5'($urandom);
    bus.rs      = 5'($urandom);
    bus.rt      = 5'($urandom);
    bus.shamt   = 5'($urandom);
    bus.aluop   = 5'($urandom);
    bus.imm     = 17'($urandom);
    bus.target  = 27'($urandom);
  endtask

  task automatic send(input logic [1:0] t, input logic [4:0] op, input logic [4:0] rd,
      input logic [4:0] rs, input logic [4:0] rt, input logic [16:0] imm, input logic [26:0] tg);
    rand_fields();
    bus.in_type = t;  bus.opcode = op; bus.rd = rd; bus.rs = rs; bus.rt = rt;
    bus.shamt   = '0; bus.aluop  = '0; bus.imm = imm; bus.target = tg;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_hs) break;
    end
    chk("send_accepted", 64'(last_hs), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         17'($urandom), 27'($urandom));
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    step();
    start_i = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic finish_and_wait(input bit rnd_mem);
    int d0;
    d0 = done_seen;
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rnd_mem) bus.mem_ready = 1'($urandom);
      step();
      if (done_seen > d0) break;
    end
    bus.mem_ready = 1'b1;
    step();
    step();
    chk("done_pulses", 64'(done_seen - d0), 64'(1));
  endtask

  initial begin
    logic [ADDR_W-1:0] h_a;
    logic [31:0]       h_d;
    bit                have;
    int                acc, wr, d0, n;

    rst = 1'b1;
    start_i = 1'b0; finish_i = 1'b0; base_addr_i = '0;
    bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
    rand_fields();
    model_reset();
    done_seen = 0;
    @(negedge clk);
    step();
    chk("rst_data", 64'(bus.imem_data), 64'(0));
    chk("rst_addr", 64'(bus.imem_addr), 64'(0));
    rst = 1'b0;
    step();

    // All four formats at base 0x010.
    bus.mem_ready = 1'b1;
    start_load(12'h010);
    send(2'd0, 5'd0, 5'd3, 5'd1, 5'd2, 17'h0, 27'h0);
    send(2'd1, 5'd5, 5'd5, 5'd0, 5'd0, 17'h1FFFF, 27'h0);
    send(2'd2, 5'd1, 5'd0, 5'd0, 5'd0, 17'h0, 27'd100);
    send(2'd3, 5'd4, 5'd31, 5'd0, 5'd0, 17'h0, 27'h0);
    finish_and_wait(1'b0);
    chk("enc_nwrites", 64'(log_data.size()), 64'(4));
    if (log_data.size() == 4) begin
      chk("enc_R", 64'(log_data[0]), 64'h00C22000);
      chk("enc_I", 64'(log_data[1]), 64'h2941FFFF);
      chk("enc_JI", 64'(log_data[2]), 64'h08000064);
      chk("enc_JII", 64'(log_data[3]), 64'h27C00000);
      chk("enc_addr0", 64'(log_addr[0]), 64'h010);
      chk("enc_addr3", 64'(log_addr[3]), 64'h013);
    end
    chk("enc_count", 64'(count_o), 64'(4));

    // Backpressure: FIFO fills, head stays put, then drains back-to-back.
    bus.mem_ready = 1'b0;
    start_load(12'h100);
    bus.in_valid = 1'b1;
    acc = 0; have = 0; h_a = '0; h_d = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_wren) begin
        if (!have) begin
          h_a = bus.imem_addr; h_d = bus.imem_data; have = 1;
        end else begin
          chk("bp_hold_addr", 64'(bus.imem_addr), 64'(h_a));
          chk("bp_hold_data", 64'(bus.imem_data), 64'(h_d));
        end
      end
      step();
      if (last_hs) acc++;
      rand_fields();
    end
    chk("bp_accepted", 64'(acc), 64'(4));
    chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    wr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_wr) wr++;
    end
    chk("bp_burst", 64'(wr), 64'(4));
    send_rand();
    send_rand();
    finish_and_wait(1'b0);
    chk("bp_count", 64'(count_o), 64'(6));

    // Address wrap at the top of imem.
    start_load(12'hFFE);
    send_rand();
    send_rand();
    send_rand();
    finish_and_wait(1'b0);
    chk("wrap_n", 64'(log_addr.size()), 64'(3));
    if (log_addr.size() == 3) begin
      chk("wrap_a0", 64'(log_addr[0]), 64'hFFE);
      chk("wrap_a1", 64'(log_addr[1]), 64'hFFF);
      chk("wrap_a2", 64'(log_addr[2]), 64'h000);
    end
    chk("wrap_ovf", 64'(overflow_o), 64'(1));
    chk("wrap_count", 64'(count_o), 64'(3));

    // Finish with nothing buffered.
    start_load(12'h050);
    step();
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    chk("ef_drain_cycle", 64'(done_o), 64'(0));
    step();
    chk("ef_done", 64'(done_o), 64'(1));
    step();
    chk("ef_nowrites", 64'(log_addr.size()), 64'(0));

    // Asynchronous reset in DRAIN with two words buffered.
    bus.mem_ready = 1'b0;
    start_load(12'h080);
    send_rand();
    send_rand();
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
    step();
    d0 = done_seen;
    #2 rst = 1'b1;
    #1;
    chk("ar_in_ready", 64'(bus.in_ready), 64'(0));
    chk("ar_wren", 64'(bus.imem_wren), 64'(0));
    chk("ar_addr", 64'(bus.imem_addr), 64'(0));
    chk("ar_data", 64'(bus.imem_data), 64'(0));
    chk("ar_count", 64'(count_o), 64'(0));
    chk("ar_busy", 64'(busy_o), 64'(0));
    chk("ar_done", 64'(done_o), 64'(0));
    model_reset();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("ar_no_done", 64'(done_seen - d0), 64'(0));
    chk("ar_no_writes", 64'(log_addr.size()), 64'(0));

    // start while loading is ignored.
    start_load(12'h200);
    start_i = 1'b1;
    base_addr_i = 12'h300;
    step();
    start_i = 1'b0;
    send_rand();
    finish_and_wait(1'b0);
    chk("sr_addr", 64'(log_addr.size() > 0 ? log_addr[0] : 12'hBAD), 64'h200);

    // start and finish together from idle: start wins.
    start_i = 1'b1;
    finish_i = 1'b1;
    base_addr_i = 12'h400;
    step();
    start_i = 1'b0;
    finish_i = 1'b0;
    log_addr.delete();
    log_data.delete();
    chk("sf_ready", 64'(bus.in_ready), 64'(1));
    chk("sf_busy", 64'(busy_o), 64'(1));
    send_rand();
    finish_and_wait(1'b0);
    chk("sf_addr", 64'(log_addr.size() > 0 ? log_addr[0] : 12'hBAD), 64'h400);

    // Random loads: random valid/mem_ready, finish possibly coincident with a handshake.
    for (int r = 0; r < 20; r++) begin
      start_load(12'($urandom));
      n = int'($urandom_range(0, 8));
      acc = 0;
      for (int i = 0; i < 200 && acc < n; i++) begin
        bus.in_valid  = 1'($urandom);
        bus.mem_ready = 1'($urandom);
        rand_fields();
        step();
        if (last_hs) acc++;
      end
      bus.in_valid = 1'($urandom);
      rand_fields();
      finish_and_wait(1'b1);
      bus.in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Instruction encoder and instruction-memory loader: the writer side of the instruction path whose opcode decode runs in the processor's control unit. It accepts instruction fields over a valid/ready handshake and packs them into 32-bit words in the processor's R/I/JI/JII formats. It buffers the words in a 4-entry FIFO and writes them to consecutive instruction-memory addresses starting at a programmed base. Used by boot/test harnesses to load programs into imem before releasing the core.

## Interface
- ADDR_W, 12, imem word-address width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  pulse; latches base_addr, clears count/overflow, enters RUN
- base_addr  in  ADDR_W  first imem address to write
- finish  in  1  pulse; no more input, drain FIFO then signal done
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted on edge where in_valid & in_ready
- in_type  in  2  0=R, 1=I, 2=JI, 3=JII
- opcode, rd, rs, rt, shamt, aluop  in  5 each  instruction fields
- imm  in  17  I-type immediate
- target  in  27  JI-type target
- imem_wren  out  1  write request
- imem_addr  out  ADDR_W  write address
- imem_data  out  32  encoded word
- mem_ready  in  1  write completes on edge where imem_wren & mem_ready
- count  out  ADDR_W+1  words written since last start
- overflow  out  1  sticky; address wrapped past 2^ADDR_W-1
- done  out  1  one-cycle pulse after drain completes
- busy  out  1  state is RUN or DRAIN

## Operation
- Encoding:
  - R: {opcode, rd, rs, rt, shamt, aluop, 2'b00}
  - I: {opcode, rd, rs, imm}
  - JI: {opcode, target}
  - JII: {opcode, rd, 22'b0}
  - Fields not used by in_type are ignored.
- State machine IDLE, RUN, DRAIN, DONE:
  - IDLE: in_ready=0, imem_wren=0. On start go to RUN, wr_addr<=base_addr, count<=0, overflow<=0.
  - RUN: in_ready = !full. Writes proceed. On finish go to DRAIN.
  - DRAIN: in_ready=0. Writes proceed. When FIFO is empty and no write completes this cycle, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. finish outside RUN is ignored. start and finish together in IDLE: start wins and finish is dropped.
- FIFO: 4 entries. Push on in handshake, pop on write completion. Push and pop in the same cycle are both performed.
- in_ready does not depend on mem_ready; a full FIFO refuses input even if a pop occurs that cycle.
- Writes:
  - imem_wren = busy & !empty.
  - imem_addr = wr_addr and imem_data = FIFO head; both hold stable while imem_wren=1 and mem_ready=0.
  - On each completion: wr_addr increments, count increments.
- Wrap: completing a write at address 2^ADDR_W-1 sets wr_addr to 0 and overflow to 1. Loading continues.

## Timing
- Reset values:
  - State IDLE, FIFO empty, wr_addr=0.
  - Outputs: in_ready=0, imem_wren=0, imem_addr=0, imem_data=0 (FIFO storage cleared), count=0, overflow=0, done=0, busy=0.
- Reset asserted mid-load: all state clears immediately. Words already written stay in imem; buffered words are lost.
- Latency:
  - A bundle accepted at edge N drives imem_wren=1 from cycle N+1 at the earliest.
  - Sustained throughput: 1 word/cycle with mem_ready held high.
- A finish arriving on the same edge as a handshake: the accepted word is still written before done.
- done rises at the earliest 2 cycles after the last write completion.
- Edge case: finish when the FIFO is empty gives DRAIN for 1 cycle, then DONE.

## Test plan
- Encode all types, base_addr=0x010, mem_ready=1, then finish:
  - R add rd=3, rs=1, rt=2, opcode 0, aluop 0 -> 0x00C22000 @0x010
  - I opcode 5, rd=5, rs=0, imm=0x1FFFF -> 0x2941FFFF @0x011
  - JI opcode 1, target=100 -> 0x08000064 @0x012
  - JII opcode 4, rd=31 -> 0x27C00000 @0x013
  - Expect count=4 and one done pulse.
- Backpressure: hold mem_ready=0 and offer 6 bundles.
  - Exactly 4 are accepted and in_ready drops.
  - imem_addr/imem_data stay stable.
  - Release mem_ready: 4 writes on consecutive cycles, then the remaining 2 are accepted.
- Wrap: ADDR_W=12, base_addr=0xFFE, 3 words -> addresses 0xFFE, 0xFFF, 0x000; overflow=1 after the second write; count=3.
- Finish with an empty FIFO in RUN -> done pulse exactly 2 cycles after finish; no imem_wren.
- Asynchronous reset asserted mid-DRAIN with 2 words buffered -> outputs at reset values immediately; no further writes; done never pulses.
- start while in RUN is ignored (base unchanged). Simultaneous start+finish in IDLE -> RUN and in_ready=1.
